proc_ctrl: RTL
==============

# proc_ctrl

Control unit for the 8-bit simple processor. It fetches an 8-bit instruction from DIN into an internal IR and sequences a 4-state machine (T0–T3). Each cycle it emits the one-hot drive enables for the tri-state drivers on the shared 8-bit BusWires, the register load enables, and the ALU controls. It sits directly upstream of every bus driver instance in the datapath and guarantees at most one driver is enabled per cycle.

## Interface
- No parameters; data width 8 and register count 8 are fixed constants in the package.
- Clock  in  1  system clock; all state updates on the rising edge.
- Resetn  in  1  synchronous, active-low reset, sampled on the rising edge of Clock.
- Run  in  1  start request; sampled only in T0.
- DIN  in  8  instruction word in T0; immediate operand in T1 of mvi.
- IRin  out  1  IR load strobe (observability).
- Rin  out  8  one-hot load enable for R0..R7.
- Rout  out  8  one-hot bus-drive enable for R0..R7 (Entern of each register's driver).
- DINout  out  1  bus-drive enable for the DIN driver.
- Gout  out  1  bus-drive enable for the G (ALU result) driver.
- Ain  out  1  load enable for ALU operand register A.
- Gin  out  1  load enable for ALU result register G.
- AddSub  out  1  0 = A+Bus, 1 = A−Bus (8-bit, carry/borrow discarded).
- Done  out  1  high in the last cycle of each instruction.
- BusErr  out  1  sticky contention flag; present only with PROC_CTRL_BUSCHK_EN.

## Operation
- IR format: IR[7:6] opcode, IR[5:3] Rx (destination), IR[2:0] Ry (source).
- Opcodes:
  - 00 mv: Rx ← Ry.
  - 01 mvi: Rx ← DIN (the second word, presented in T1).
  - 10 add: Rx ← Rx+Ry.
  - 11 sub: Rx ← Rx−Ry.
- States:
  - T0: idle/fetch. IRin = Run. If Run, IR ← DIN and next = T1; otherwise stay in T0. Nothing drives the bus.
  - T1:
    - mv: Rout[Ry], Rin[Rx], Done; next T0.
    - mvi: DINout, Rin[Rx], Done; next T0.
    - add/sub: Rout[Rx], Ain; next T2.
  - T2 (add/sub only): Rout[Ry], Gin, AddSub = opcode[0]; next T3.
  - T3 (add/sub only): Gout, Rin[Rx], Done; next T0.
- Outputs are decoded combinationally from the state register and IR. Every enable not listed for a state is 0.
- Bus exclusivity: the 10 drive enables (Rout[7:0], DINout, Gout) are at most one-hot in every state. mv with Rx = Ry is legal: the same register drives the bus and reloads from it.
- IR holds its value from the T0 load until the next T0 load.

## Timing
- Reset: when Resetn = 0 at a rising edge, state ← T0 and IR ← 8'h00. All outputs are then 0 except IRin, which follows Run.
- While Resetn is low, all outputs except IRin are additionally forced to 0 combinationally. This makes reset mid-instruction release the bus immediately and abort the instruction, with no Rin or Gin pulse.
- Latency from the Run-sampling edge to the Done cycle:
  - mv/mvi: Done in the cycle immediately after the T0 edge (2 cycles per instruction).
  - add/sub: Done 3 cycles after the T0 edge (4 cycles per instruction).
- Back-to-back instructions: after Done the FSM always passes through one T0 cycle. Run held high fetches the next instruction in that T0.
- Run changes outside T0 are ignored.
- DIN must be stable at the T0 edge (instruction) and at the mvi T1 edge (immediate).

## Configuration
- PROC_CTRL_BUSCHK_EN defined:
  - BusErr port exists.
  - BusErr is set on any rising edge where more than one drive enable is high.
  - BusErr is sticky until the Resetn edge; its reset value is 0.
- Undefined: the port and checker logic are absent. Functional behaviour is otherwise identical.

## Structure
- Package proc_pkg holds:
  - opcode constants OP_MV = 2'b00, OP_MVI = 2'b01, OP_ADD = 2'b10, OP_SUB = 2'b11;
  - state encoding T0..T3 (2-bit);
  - constants DATA_W = 8 and NUM_REGS = 8.
- One sub-module: dec3to8, a 3-bit to one-hot 8-bit decoder with an enable input. It is instantiated twice, for Rx and for Ry, and the results are muxed onto Rin and Rout.

## Test plan
- Reset then mvi R2: Resetn low for 2 cycles, then Run = 1 with DIN = 0x50, then DIN = 0x5A. Required: next cycle DINout = 1, Rin = 8'b0000_0100, Done = 1, Rout = 0, Gout = 0; the cycle after returns to T0 with all enables 0.
- mv R5,R2 (DIN = 0x2A): in T1, Rout = 8'b0000_0100, Rin = 8'b0010_0000, Done = 1; exactly 2 cycles from Run-sample to T0.
- add R1,R3 (0x8B):
  - T1: Rout = 0x02, Ain = 1.
  - T2: Rout = 0x08, Gin = 1, AddSub = 0.
  - T3: Gout = 1, Rin = 0x02, Done = 1.
- sub R1,R3 (0xCB): same sequence as add, except AddSub = 1 in T2. With the datapath attached, R1 = 0x10 and R3 = 0x30 give R1 = 0xE0.
- Reset mid-instruction: during add T2, Resetn = 0. Required: all enables 0 combinationally; next state T0; IR = 0x00; no Rin pulse. Run held high through Done immediately fetches the next word in T0.
- PROC_CTRL_BUSCHK_EN:
  - Normal instruction stream: BusErr stays 0.
  - Forcing two enables via an injected bind/force: BusErr = 1 at the next edge, held until Resetn.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared constants and types for the 8-bit processor control unit.
// Optional bus checker elsewhere is enabled with PROC_CTRL_BUSCHK_EN.
package proc_pkg;

    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 8;

    localparam logic [1:0] OP_MV  = 2'b00;
    localparam logic [1:0] OP_MVI = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_e;

    function automatic logic multi_drv(input logic [NUM_REGS+1:0] v);
        return |(v & (v - 1'b1));
    endfunction

endpackage

// File: rtl/dec3to8.sv
// 3-bit index to one-hot register select, gated by an enable.
module dec3to8
    import proc_pkg::*;
(
    input  logic [2:0]          w_i,
    input  logic                en_i,
    output logic [NUM_REGS-1:0] y_o
);

    assign y_o = en_i ? (NUM_REGS'(1) << w_i) : '0;

endmodule

// File: rtl/proc_ctrl.sv
// T0-T3 control FSM for the 8-bit processor: IR fetch, bus drive and load enables.
// Define PROC_CTRL_BUSCHK_EN to add the sticky BusErr contention flag.
module proc_ctrl
    import proc_pkg::*;
(
    input  logic                Clock,
    input  logic                Resetn,
    input  logic                Run,
    input  logic [DATA_W-1:0]   DIN,
    output logic                IRin,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic                DINout,
    output logic                Gout,
    output logic                Ain,
    output logic                Gin,
    output logic                AddSub,
`ifdef PROC_CTRL_BUSCHK_EN
    output logic                BusErr,
`endif
    output logic                Done
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [1:0]          op;
    logic [NUM_REGS-1:0] rx_oh, ry_oh;
    logic                rin_x, rout_x, rout_y;

    assign op = ir_q[7:6];

    dec3to8 u_dec_rx (.w_i(ir_q[5:3]), .en_i(Resetn), .y_o(rx_oh));
    dec3to8 u_dec_ry (.w_i(ir_q[2:0]), .en_i(Resetn), .y_o(ry_oh));

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        unique case (state_q)
            T0: begin
                if (Run) begin
                    state_d = T1;
                    ir_d    = DIN;
                end
            end
            T1:      state_d = op[1] ? T2 : T0;
            T2:      state_d = T3;
            default: state_d = T0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Resetn gates every enable so an aborted instruction releases the bus at once.
    always_comb begin
        rin_x  = 1'b0;
        rout_x = 1'b0;
        rout_y = 1'b0;
        DINout = 1'b0;
        Gout   = 1'b0;
        Ain    = 1'b0;
        Gin    = 1'b0;
        AddSub = 1'b0;
        Done   = 1'b0;
        if (Resetn) begin
            unique case (state_q)
                T0: ;
                T1: begin
                    unique case (op)
                        OP_MV: begin
                            rout_y = 1'b1;
                            rin_x  = 1'b1;
                            Done   = 1'b1;
                        end
                        OP_MVI: begin
                            DINout = 1'b1;
                            rin_x  = 1'b1;
                            Done   = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            rout_x = 1'b1;
                            Ain    = 1'b1;
                        end
                    endcase
                end
                T2: begin
                    rout_y = 1'b1;
                    Gin    = 1'b1;
                    AddSub = op[0];
                end
                T3: begin
                    Gout  = 1'b1;
                    rin_x = 1'b1;
                    Done  = 1'b1;
                end
            endcase
        end
    end

    assign IRin = Run & (state_q == T0);
    assign Rin  = rin_x ? rx_oh : '0;
    assign Rout = rout_x ? rx_oh : (rout_y ? ry_oh : '0);

`ifdef PROC_CTRL_BUSCHK_EN
    logic buserr_q;

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            buserr_q <= 1'b0;
        end else if (multi_drv({Rout, DINout, Gout})) begin
            buserr_q <= 1'b1;
        end
    end

    assign BusErr = buserr_q;
`endif

endmodule
